snes_mem_responder: RTL and testbench

Memory-side responder for SNES bus cycles after address decoding. It synchronizes the raw SNES read/write strobes and waits for the address and data lines to settle. It then samples the decoded ROM/save-RAM address and hit flags, issues a single request/acknowledge transaction to the external memory controller, and drives the fetched byte onto the SNES data bus for the remainder of the read strobe. It sits between the address decoder and the SRAM controller.

---
 rtl/snes_mem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_snes_mem_responder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snes_mem_responder.sv
// SNES bus responder: strobe sync, settle, one mem request per bus cycle.
// Optional ack timeout enabled by defining SNES_MEM_RESP_TIMEOUT_EN.
`timescale 1ns/1ps
module snes_mem_responder #(
  parameter int SETTLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 24
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SNES_RD_N,
  input  logic        SNES_WR_N,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DATA_IN,
  output logic [7:0]  SNES_DATA_OUT,
  output logic        SNES_DATA_OE,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [23:0] MEM_ADDR,
  output logic [7:0]  MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_RDATA,
  output logic        BUSY,
  output logic        ERR_TIMEOUT
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_to
    $error("TIMEOUT_CYCLES out of range");
  end

  localparam logic [3:0] LP_SET_LAST = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE, S_SETTLE, S_REQ, S_HOLD
  } state_t;

  state_t      r_state, w_state_nx;
  logic [2:0]  r_rd_sync, r_wr_sync;
  logic        r_rd_fall, r_wr_fall;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic        r_is_wr, w_is_wr_nx;
  logic        r_abort, w_abort_nx;
  logic        r_mem_req, w_req_nx;
  logic        r_mem_we, w_we_nx;
  logic [23:0] r_mem_addr, w_addr_nx;
  logic [7:0]  r_mem_wdata, w_wdata_nx;
  logic [7:0]  r_dout, w_dout_nx;
  logic        r_oe, w_oe_nx;
  logic        w_strobe_hi;
  logic        w_access_ok;

`ifdef SNES_MEM_RESP_TIMEOUT_EN
  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] r_tcnt, w_tcnt_nx;
  logic       r_err, w_err_nx;
`endif

  assign w_strobe_hi = r_is_wr ? r_wr_sync[1] : r_rd_sync[1];
  assign w_access_ok = r_is_wr ? IS_WRITABLE : ROM_HIT;

  // Two-flop synchronizers, history flop and registered falling edge
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_sync <= 3'b111;
      r_wr_sync <= 3'b111;
      r_rd_fall <= 1'b0;
      r_wr_fall <= 1'b0;
    end else begin
      r_rd_sync <= {r_rd_sync[1:0], SNES_RD_N};
      r_wr_sync <= {r_wr_sync[1:0], SNES_WR_N};
      r_rd_fall <= r_rd_sync[2] & ~r_rd_sync[1];
      r_wr_fall <= r_wr_sync[2] & ~r_wr_sync[1];
    end
  end

  // Next-state and next-output decode for the bus-cycle FSM
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_is_wr_nx = r_is_wr;
    w_abort_nx = r_abort;
    w_req_nx   = r_mem_req;
    w_we_nx    = r_mem_we;
    w_addr_nx  = r_mem_addr;
    w_wdata_nx = r_mem_wdata;
    w_dout_nx  = r_dout;
    w_oe_nx    = r_oe;
`ifdef SNES_MEM_RESP_TIMEOUT_EN
    w_tcnt_nx  = r_tcnt;
    w_err_nx   = r_err;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (r_rd_fall | r_wr_fall) begin
          w_state_nx = S_SETTLE;
          w_cnt_nx   = 4'd0;
          w_is_wr_nx = r_wr_fall;
        end
      end
      S_SETTLE: begin
        if (w_strobe_hi) begin
          w_state_nx = S_IDLE;
        end else if (r_cnt == LP_SET_LAST) begin
          if (w_access_ok) begin
            w_state_nx = S_REQ;
            w_req_nx   = 1'b1;
            w_we_nx    = r_is_wr;
            w_addr_nx  = ROM_ADDR;
            w_wdata_nx = SNES_DATA_IN;
            w_abort_nx = 1'b0;
`ifdef SNES_MEM_RESP_TIMEOUT_EN
            w_tcnt_nx  = 8'd0;
`endif
          end else begin
            w_state_nx = S_HOLD;
          end
        end else begin
          w_cnt_nx = r_cnt + 4'd1;
        end
      end
      S_REQ: begin
        w_abort_nx = r_abort | w_strobe_hi;
        if (MEM_ACK) begin
          w_req_nx   = 1'b0;
          w_state_nx = S_HOLD;
          if (!r_mem_we && !w_abort_nx) begin
            w_dout_nx = MEM_RDATA;
            w_oe_nx   = 1'b1;
          end
        end
`ifdef SNES_MEM_RESP_TIMEOUT_EN
        else if (r_tcnt == LP_TO_LAST) begin
          w_req_nx   = 1'b0;
          w_err_nx   = 1'b1;
          w_state_nx = S_HOLD;
          if (!r_mem_we && !w_abort_nx) begin
            w_dout_nx = 8'hFF;
            w_oe_nx   = 1'b1;
          end
        end else begin
          w_tcnt_nx = r_tcnt + 8'd1;
        end
`endif
      end
      S_HOLD: begin
        if (w_strobe_hi) begin
          w_oe_nx    = 1'b0;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_is_wr     <= 1'b0;
      r_abort     <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 24'd0;
      r_mem_wdata <= 8'd0;
      r_dout      <= 8'd0;
      r_oe        <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_is_wr     <= w_is_wr_nx;
      r_abort     <= w_abort_nx;
      r_mem_req   <= w_req_nx;
      r_mem_we    <= w_we_nx;
      r_mem_addr  <= w_addr_nx;
      r_mem_wdata <= w_wdata_nx;
      r_dout      <= w_dout_nx;
      r_oe        <= w_oe_nx;
    end
  end

`ifdef SNES_MEM_RESP_TIMEOUT_EN
  // Ack-wait counter and sticky timeout flag
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tcnt <= 8'd0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_nx;
      r_err  <= w_err_nx;
    end
  end
  assign ERR_TIMEOUT = r_err;
`else
  assign ERR_TIMEOUT = 1'b0;
`endif

  assign BUSY          = (r_state != S_IDLE);
  assign MEM_REQ       = r_mem_req;
  assign MEM_WE        = r_mem_we;
  assign MEM_ADDR      = r_mem_addr;
  assign MEM_WDATA     = r_mem_wdata;
  assign SNES_DATA_OUT = r_dout;
  assign SNES_DATA_OE  = r_oe;

endmodule

// File: tb/tb_snes_mem_responder.sv
// Scoreboard bench for snes_mem_responder.
// Expected requests queued at stimulus time, popped when MEM_REQ rises.
`timescale 1ns/1ps
module tb_snes_mem_responder;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SNES_RD_N = 1'b1;
  logic        SNES_WR_N = 1'b1;
  logic [23:0] ROM_ADDR = '0;
  logic        ROM_HIT = 1'b0;
  logic        IS_WRITABLE = 1'b0;
  logic [7:0]  SNES_DATA_IN = '0;
  logic [7:0]  SNES_DATA_OUT;
  logic        SNES_DATA_OE;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic [7:0]  MEM_RDATA = '0;
  logic        BUSY;
  logic        ERR_TIMEOUT;

  snes_mem_responder dut (
    .CLK(CLK), .RST_N(RST_N),
    .SNES_RD_N(SNES_RD_N), .SNES_WR_N(SNES_WR_N),
    .ROM_ADDR(ROM_ADDR), .ROM_HIT(ROM_HIT),
    .IS_WRITABLE(IS_WRITABLE),
    .SNES_DATA_IN(SNES_DATA_IN),
    .SNES_DATA_OUT(SNES_DATA_OUT),
    .SNES_DATA_OE(SNES_DATA_OE),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .BUSY(BUSY), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        we;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t exp_q[$];
  req_t e;
  int   checks = 0;
  int   failures = 0;
  int   req_rises = 0;
  int   oe_cycles = 0;
  logic prev_req = 1'b0;
  bit   ok;

  always @(posedge CLK) begin
    if (MEM_REQ && !prev_req) req_rises++;
    prev_req = MEM_REQ;
    if (SNES_DATA_OE) oe_cycles++;
  end

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK); #1;
      if (MEM_REQ) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (MEM_REQ !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL reset_req_busy got=%b%b want=00", MEM_REQ, BUSY);
    end
    checks++;
    if (SNES_DATA_OE !== 1'b0 || SNES_DATA_OUT !== 8'h00) begin
      failures++;
      $display("FAIL reset_oe_dout got=%b/%h want=0/00",
               SNES_DATA_OE, SNES_DATA_OUT);
    end
    checks++;
    if (ERR_TIMEOUT !== 1'b0 || MEM_ADDR !== 24'h0) begin
      failures++;
      $display("FAIL reset_err_addr got=%b/%h want=0/000000",
               ERR_TIMEOUT, MEM_ADDR);
    end
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_valid_read();
    @(negedge CLK);
    ROM_ADDR = 24'h012345; ROM_HIT = 1'b1; IS_WRITABLE = 1'b0;
    SNES_RD_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b0, addr: 24'h012345, wdata: 8'h00});
    repeat (6) @(posedge CLK); #1;
    checks++;
    if (MEM_REQ !== 1'b0) begin
      failures++;
      $display("FAIL read_req_edge5 got=%b want=0", MEM_REQ);
    end
    @(posedge CLK); #1;
    checks++;
    if (MEM_REQ !== 1'b1) begin
      failures++;
      $display("FAIL read_req_edge6 got=%b want=1", MEM_REQ);
    end
    e = exp_q.pop_front();
    checks++;
    if (MEM_WE !== e.we || MEM_ADDR !== e.addr) begin
      failures++;
      $display("FAIL read_req_fields got=%b/%h want=%b/%h",
               MEM_WE, MEM_ADDR, e.we, e.addr);
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    MEM_ACK = 1'b1; MEM_RDATA = 8'hA5;
    @(posedge CLK); #1;
    checks++;
    if (MEM_REQ !== 1'b0 || SNES_DATA_OE !== 1'b1 ||
        SNES_DATA_OUT !== 8'hA5) begin
      failures++;
      $display("FAIL read_ack got=req%b oe%b %h want=req0 oe1 a5",
               MEM_REQ, SNES_DATA_OE, SNES_DATA_OUT);
    end
    @(negedge CLK);
    MEM_ACK = 1'b0;
    repeat (8) @(negedge CLK);
    checks++;
    if (SNES_DATA_OE !== 1'b1) begin
      failures++;
      $display("FAIL read_oe_held got=%b want=1", SNES_DATA_OE);
    end
    SNES_RD_N = 1'b1;
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (SNES_DATA_OE !== 1'b0 || SNES_DATA_OUT !== 8'hA5 ||
        BUSY !== 1'b0) begin
      failures++;
      $display("FAIL read_release got=oe%b %h busy%b want=oe0 a5 busy0",
               SNES_DATA_OE, SNES_DATA_OUT, BUSY);
    end
  endtask

  task automatic test_write();
    @(negedge CLK);
    oe_cycles = 0; req_rises = 0;
    ROM_ADDR = 24'hE00010; SNES_DATA_IN = 8'h3C;
    IS_WRITABLE = 1'b1; ROM_HIT = 1'b1;
    SNES_WR_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b1, addr: 24'hE00010, wdata: 8'h3C});
    wait_req(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL write_req got=timeout want=MEM_REQ");
    end else if (MEM_WE !== e.we || MEM_WDATA !== e.wdata ||
                 MEM_ADDR !== e.addr) begin
      failures++;
      $display("FAIL write_fields got=%b/%h/%h want=%b/%h/%h",
               MEM_WE, MEM_ADDR, MEM_WDATA, e.we, e.addr, e.wdata);
    end
    @(negedge CLK); MEM_ACK = 1'b1;
    @(negedge CLK); MEM_ACK = 1'b0;
    repeat (4) @(negedge CLK);
    SNES_WR_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (req_rises !== 1 || oe_cycles !== 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL write_done got=reqs%0d oe%0d busy%b want=1 0 0",
               req_rises, oe_cycles, BUSY);
    end
  endtask

  task automatic test_glitch_unmapped();
    @(negedge CLK);
    req_rises = 0; oe_cycles = 0;
    ROM_HIT = 1'b1; SNES_RD_N = 1'b0;
    repeat (2) @(negedge CLK);
    SNES_RD_N = 1'b1;
    repeat (10) @(negedge CLK);
    checks++;
    if (req_rises !== 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL glitch got=reqs%0d busy%b want=0 0", req_rises, BUSY);
    end
    ROM_HIT = 1'b0; SNES_RD_N = 1'b0;
    repeat (12) @(negedge CLK);
    checks++;
    if (req_rises !== 0 || oe_cycles !== 0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_rd got=reqs%0d oe%0d busy%b want=0 0 1",
               req_rises, oe_cycles, BUSY);
    end
    SNES_RD_N = 1'b1;
    repeat (5) @(negedge CLK);
    IS_WRITABLE = 1'b0; ROM_HIT = 1'b1; SNES_WR_N = 1'b0;
    repeat (12) @(negedge CLK);
    SNES_WR_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (req_rises !== 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL unwritable got=reqs%0d busy%b want=0 0",
               req_rises, BUSY);
    end
  endtask

  task automatic test_early_release();
    @(negedge CLK);
    oe_cycles = 0;
    ROM_ADDR = 24'h0ABCDE; ROM_HIT = 1'b1; SNES_RD_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b0, addr: 24'h0ABCDE, wdata: 8'h00});
    wait_req(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || MEM_ADDR !== e.addr || MEM_WE !== e.we) begin
      failures++;
      $display("FAIL early_req got=%b %b/%h want=1 %b/%h",
               ok, MEM_WE, MEM_ADDR, e.we, e.addr);
    end
    @(negedge CLK); SNES_RD_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b1) begin
      failures++;
      $display("FAIL early_req_held got=%b want=1", MEM_REQ);
    end
    MEM_ACK = 1'b1; MEM_RDATA = 8'h5A;
    @(negedge CLK); MEM_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (MEM_REQ !== 1'b0 || oe_cycles !== 0 ||
        SNES_DATA_OUT !== 8'hA5 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL early_done got=req%b oe%0d %h busy%b want=0 0 a5 0",
               MEM_REQ, oe_cycles, SNES_DATA_OUT, BUSY);
    end
  endtask

  task automatic test_simultaneous();
    @(negedge CLK);
    oe_cycles = 0;
    ROM_ADDR = 24'h123456; SNES_DATA_IN = 8'h77;
    ROM_HIT = 1'b1; IS_WRITABLE = 1'b1;
    SNES_RD_N = 1'b0; SNES_WR_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b1, addr: 24'h123456, wdata: 8'h77});
    wait_req(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || MEM_WE !== e.we || MEM_WDATA !== e.wdata ||
        MEM_ADDR !== e.addr) begin
      failures++;
      $display("FAIL both_edges got=%b %b/%h/%h want=1 %b/%h/%h",
               ok, MEM_WE, MEM_ADDR, MEM_WDATA, e.we, e.addr, e.wdata);
    end
    @(negedge CLK); MEM_ACK = 1'b1;
    @(negedge CLK); MEM_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    SNES_RD_N = 1'b1; SNES_WR_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (oe_cycles !== 0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL both_done got=oe%0d busy%b want=0 0", oe_cycles, BUSY);
    end
  endtask

  task automatic test_timeout();
    int drops;
    @(negedge CLK);
    ROM_ADDR = 24'h00FFEE; ROM_HIT = 1'b1; SNES_RD_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b0, addr: 24'h00FFEE, wdata: 8'h00});
    wait_req(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || MEM_ADDR !== e.addr) begin
      failures++;
      $display("FAIL to_req got=%b %h want=1 %h", ok, MEM_ADDR, e.addr);
    end
`ifdef SNES_MEM_RESP_TIMEOUT_EN
    drops = 0;
    repeat (23) @(posedge CLK); #1;
    checks++;
    if (MEM_REQ !== 1'b1) begin
      failures++;
      $display("FAIL to_req_23 got=%b want=1", MEM_REQ);
    end
    @(posedge CLK); #1;
    checks++;
    if (MEM_REQ !== 1'b0 || ERR_TIMEOUT !== 1'b1 ||
        SNES_DATA_OE !== 1'b1 || SNES_DATA_OUT !== 8'hFF) begin
      failures++;
      $display("FAIL to_fire got=req%b err%b oe%b %h want=0 1 1 ff",
               MEM_REQ, ERR_TIMEOUT, SNES_DATA_OE, SNES_DATA_OUT);
    end
    @(negedge CLK); SNES_RD_N = 1'b1;
    repeat (5) @(negedge CLK);
    checks++;
    if (SNES_DATA_OE !== 1'b0 || ERR_TIMEOUT !== 1'b1 || drops !== 0) begin
      failures++;
      $display("FAIL to_after got=oe%b err%b want=0 1",
               SNES_DATA_OE, ERR_TIMEOUT);
    end
`else
    drops = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      if (MEM_REQ !== 1'b1) drops++;
    end
    checks++;
    if (drops !== 0 || ERR_TIMEOUT !== 1'b0) begin
      failures++;
      $display("FAIL no_timeout got=drops%0d err%b want=0 0",
               drops, ERR_TIMEOUT);
    end
    @(negedge CLK); MEM_ACK = 1'b1; MEM_RDATA = 8'h11;
    @(posedge CLK); #1;
    checks++;
    if (MEM_REQ !== 1'b0 || SNES_DATA_OE !== 1'b1 ||
        SNES_DATA_OUT !== 8'h11) begin
      failures++;
      $display("FAIL late_ack got=req%b oe%b %h want=0 1 11",
               MEM_REQ, SNES_DATA_OE, SNES_DATA_OUT);
    end
    @(negedge CLK); MEM_ACK = 1'b0; SNES_RD_N = 1'b1;
    repeat (5) @(negedge CLK);
`endif
  endtask

  task automatic test_reset_in_req();
    @(negedge CLK);
    ROM_ADDR = 24'h045678; ROM_HIT = 1'b1; SNES_RD_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b0, addr: 24'h045678, wdata: 8'h00});
    wait_req(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || MEM_ADDR !== e.addr) begin
      failures++;
      $display("FAIL rst_req got=%b %h want=1 %h", ok, MEM_ADDR, e.addr);
    end
    @(negedge CLK); #2;
    RST_N = 1'b0;
    #1;
    checks++;
    if (MEM_REQ !== 1'b0 || BUSY !== 1'b0 || SNES_DATA_OE !== 1'b0) begin
      failures++;
      $display("FAIL async_rst got=req%b busy%b oe%b want=0 0 0",
               MEM_REQ, BUSY, SNES_DATA_OE);
    end
    SNES_RD_N = 1'b1;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    ROM_ADDR = 24'h0000AA; SNES_RD_N = 1'b0;
    exp_q.push_back(req_t'{we: 1'b0, addr: 24'h0000AA, wdata: 8'h00});
    wait_req(ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || MEM_ADDR !== e.addr || MEM_WE !== e.we) begin
      failures++;
      $display("FAIL post_rst_req got=%b %b/%h want=1 %b/%h",
               ok, MEM_WE, MEM_ADDR, e.we, e.addr);
    end
    @(negedge CLK); MEM_ACK = 1'b1; MEM_RDATA = 8'hC3;
    @(posedge CLK); #1;
    checks++;
    if (SNES_DATA_OE !== 1'b1 || SNES_DATA_OUT !== 8'hC3) begin
      failures++;
      $display("FAIL post_rst_data got=oe%b %h want=1 c3",
               SNES_DATA_OE, SNES_DATA_OUT);
    end
    @(negedge CLK); MEM_ACK = 1'b0;
    repeat (2) @(negedge CLK);
    SNES_RD_N = 1'b1;
    repeat (3) @(posedge CLK); #1;
    checks++;
    if (SNES_DATA_OE !== 1'b0 || BUSY !== 1'b0) begin
      failures++;
      $display("FAIL post_rst_end got=oe%b busy%b want=0 0",
               SNES_DATA_OE, BUSY);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=hang want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_valid_read();
    test_write();
    test_glitch_unmapped();
    test_early_release();
    test_simultaneous();
    test_timeout();
    test_reset_in_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
